ofifo_deskew: RTL and testbench

Output collection stage directly downstream of the systolic MAC array. It captures each column's bottom-of-array partial sum independently when that column's valid bit is set, which absorbs the one-cycle-per-column skew. It releases a full, aligned row of `col` psums only when every column holds data. It feeds the SRAM write-back / accumulation path.

---
 rtl/ofifo_deskew.sv | 109 ++++++++++
 tb/tb_ofifo_deskew.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofifo_deskew.sv
// Output deskew FIFO behind the systolic MAC array: every column captures its own
// psums as they arrive, and a row is released only when all columns hold one.
module ofifo_deskew #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ovf
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] cnt_full = cw'(depth);

  // Handshake: wr[c] pushes lane c with no ready toward the array (a push to a full
  // column with no pop is dropped and flagged in o_ovf); rd pops a row only while
  // o_valid is high, otherwise it is ignored.

  logic [psum_bw-1:0] mem_q  [col][depth];
  logic [psum_bw-1:0] mem_d  [col][depth];
  logic [aw-1:0]      wptr_q [col];
  logic [aw-1:0]      wptr_d [col];
  logic [cw-1:0]      cnt_q  [col];
  logic [cw-1:0]      cnt_d  [col];
  logic [aw-1:0]      rptr_q;
  logic [aw-1:0]      rptr_d;
  logic               ovf_q;
  logic               ovf_d;

  logic               pop;
  logic [col-1:0]     push;
  logic [col-1:0]     drop;

  // Status comes from registered counts only, so rd/wr never reach it combinationally.
  always_comb begin
    o_valid = 1'b1;
    o_full  = 1'b0;
    for (int c = 0; c < col; c++) begin
      if (cnt_q[c] == '0)      o_valid = 1'b0;
      if (cnt_q[c] == cnt_full) o_full = 1'b1;
    end
  end

  assign pop   = rd && o_valid;
  assign o_ovf = ovf_q;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    push   = '0;
    drop   = '0;
    if (pop) rptr_d = rptr_q + 1'b1;
    for (int c = 0; c < col; c++) begin
      // A pop in the same cycle frees a slot, so a full column may still accept.
      push[c] = wr[c] && ((cnt_q[c] != cnt_full) || pop);
      drop[c] = wr[c] && !push[c];
      if (push[c]) begin
        mem_d[c][wptr_q[c]] = in[c*psum_bw +: psum_bw];
        wptr_d[c]           = wptr_q[c] + 1'b1;
      end
      case ({push[c], pop})
        2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
        2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
    if (|drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset; counts say what is meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    out = '0;
    for (int c = 0; c < col; c++) begin
      out[c*psum_bw +: psum_bw] = mem_q[c][rptr_q];
    end
  end

endmodule

// File: tb/tb_ofifo_deskew.sv
// Directed bench for ofifo_deskew: reset, skewed capture, fill/overflow,
// push+pop at full, streaming with wrap, ignored read and mid-run reset.
module tb_ofifo_deskew;

  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int W   = COL * PBW;

  logic           clk;
  logic           reset;
  logic [W-1:0]   din;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   dout;
  logic           o_valid;
  logic           o_full;
  logic           o_ovf;

  int n_checks;
  int n_errors;
  int popped;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_row;

  ofifo_deskew #(.col(COL), .psum_bw(PBW), .depth(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (din),
    .wr      (wr),
    .rd      (rd),
    .out     (dout),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ovf   (o_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] row(input int k);
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PBW +: PBW] = PBW'(k);
    return r;
  endfunction

  function automatic logic [W-1:0] stream_row(input int r);
    logic [W-1:0] v;
    for (int c = 0; c < COL; c++) v[c*PBW +: PBW] = PBW'((r << 4) | c);
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    wr    = 8'hFF;
    rd    = 1'b0;
    din   = row(16'hDEAD);

    // reset with writes asserted
    step();
    step();
    reset = 1'b1;
    wr    = '0;
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_full",  W'(o_full),  W'(0));
    check("rst_ovf",   W'(o_ovf),   W'(0));
    step();
    check("rst_no_store", W'(o_valid), W'(0));

    // skewed capture
    for (int c = 0; c < COL; c++) din[c*PBW +: PBW] = PBW'(16'h0100 + c);
    for (int c = 0; c < COL; c++) begin
      wr    = '0;
      wr[c] = 1'b1;
      step();
      if (c < COL - 1) check("skew_valid_low", W'(o_valid), W'(0));
    end
    wr = '0;
    check("skew_valid_high", W'(o_valid), W'(1));
    check("skew_out", dout, {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                             16'h0103, 16'h0102, 16'h0101, 16'h0100});
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("skew_pop_empty", W'(o_valid), W'(0));

    // fill, full, overflow
    for (int k = 0; k < 8; k++) begin
      wr  = 8'hFF;
      din = row(k);
      step();
      if (k == 6) check("fill_not_full", W'(o_full), W'(0));
    end
    check("fill_full", W'(o_full), W'(1));
    check("fill_no_ovf", W'(o_ovf), W'(0));
    din = row(16'h00AA);
    step();
    wr = '0;
    check("fill_ovf", W'(o_ovf), W'(1));
    for (int k = 0; k < 8; k++) begin
      check("fill_out", dout, row(k));
      rd = 1'b1;
      step();
      rd = 1'b0;
      if (k == 0) check("fill_full_drop", W'(o_full), W'(0));
    end
    check("fill_drained", W'(o_valid), W'(0));
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("ovf_cleared", W'(o_ovf), W'(0));

    // simultaneous push/pop at full
    for (int k = 0; k < 8; k++) begin
      wr  = (k < 5) ? 8'hFF : 8'hFE;
      din = row(k);
      step();
    end
    for (int k = 5; k < 8; k++) begin
      wr  = 8'h01;
      din = row(k);
      step();
    end
    wr = '0;
    check("simul_full", W'(o_full), W'(1));
    wr  = 8'hFF;
    din = row(16'h0050);
    rd  = 1'b1;
    check("simul_head", dout, row(0));
    step();
    wr = '0;
    rd = 1'b0;
    check("simul_still_full", W'(o_full), W'(1));
    check("simul_no_ovf", W'(o_ovf), W'(0));
    for (int k = 1; k <= 8; k++) begin
      exp_row = (k < 8) ? row(k) : row(16'h0050);
      check("simul_out", dout, exp_row);
      rd = 1'b1;
      step();
      rd = 1'b0;
      if (k == 1) check("simul_full_drop", W'(o_full), W'(0));
    end
    check("simul_drained", W'(o_valid), W'(0));

    // streaming 40 skewed rows with rd held high
    for (int r = 0; r < 40; r++) exp_q.push_back(stream_row(r));
    popped = 0;
    rd     = 1'b1;
    for (int t = 0; t < 70; t++) begin
      wr = '0;
      for (int c = 0; c < COL; c++) begin
        if (t - c >= 0 && t - c < 40) begin
          wr[c] = 1'b1;
          din[c*PBW +: PBW] = PBW'(((t - c) << 4) | c);
        end
      end
      if (o_valid) begin
        if (exp_q.size() > 0) check("stream_row", dout, exp_q.pop_front());
        else check("stream_extra_row", W'(o_valid), W'(0));
        popped++;
      end
      step();
    end
    rd = 1'b0;
    wr = '0;
    check("stream_count", W'(popped), W'(40));
    check("stream_no_ovf", W'(o_ovf), W'(0));
    check("stream_drained", W'(o_valid), W'(0));

    // ignored read with column 3 empty
    wr  = 8'hF7;
    din = row(16'h0033);
    step();
    wr = '0;
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("ign_valid", W'(o_valid), W'(0));
    wr  = 8'h08;
    din = row(16'h0044);
    step();
    wr = '0;
    check("ign_valid_after", W'(o_valid), W'(1));
    exp_row = row(16'h0033);
    exp_row[3*PBW +: PBW] = 16'h0044;
    check("ign_out", dout, exp_row);

    // mid-run reset discards rows plus same-cycle push/pop
    reset = 1'b0;
    wr    = 8'hFF;
    rd    = 1'b1;
    din   = row(16'h0077);
    step();
    reset = 1'b1;
    wr    = '0;
    rd    = 1'b0;
    check("mrst_valid", W'(o_valid), W'(0));
    check("mrst_full",  W'(o_full),  W'(0));
    check("mrst_ovf",   W'(o_ovf),   W'(0));
    wr  = 8'hFF;
    din = row(16'h0066);
    step();
    wr = '0;
    check("mrst_new_valid", W'(o_valid), W'(1));
    check("mrst_new_out", dout, row(16'h0066));
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("mrst_single_row", W'(o_valid), W'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
